// File: rtl/speed_test_controller_seq.sv
`default_nettype none
// ============================================================================
// Module      : speed_test_controller_seq
// Description : Run sequencer for the multi-port speed tester. Polls the
//               host control memory for a go command, loads per-port config,
//               starts/stops the enabled generator/checker pairs, writes the
//               per-port results back and publishes status with a run count.
// Revision    : 1.0 - initial release
// ============================================================================
module speed_test_controller_seq #(
    parameter int MEM_ADDR_WIDTH = 9,
    parameter int TEST_PORT      = 4,
    parameter int RES_WORDS      = 2,
    parameter int READY_TIMEOUT  = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
    output logic [63:0]                       mem_din,
    input  logic [63:0]                       mem_dout,
    input  logic [TEST_PORT-1:0]              gen_ready,
    input  logic [TEST_PORT-1:0]              check_ready,
    input  logic [TEST_PORT*RES_WORDS*64-1:0] check_results,
    output logic [TEST_PORT-1:0]              start,
    output logic [TEST_PORT-1:0]              stop,
    output logic [TEST_PORT*64-1:0]           port_config
);

    localparam int c_cfg_base = 2;
    localparam int c_res_base = 2 + TEST_PORT;
    localparam int c_pw       = $clog2(TEST_PORT + 1);
    localparam int c_ww       = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
    localparam int c_cnt_w    = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(READY_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD_CFG   = 4'd1,
        S_WAIT_READY = 4'd2,
        S_START      = 4'd3,
        S_TESTING    = 4'd4,
        S_STOP       = 4'd5,
        S_DRAIN      = 4'd6,
        S_WRITEBACK  = 4'd7,
        S_FINISH     = 4'd8
    } state_t;

    state_t                         r_state;
    logic                           r_mem_we;
    logic [MEM_ADDR_WIDTH-1:0]      r_mem_addr;
    logic [63:0]                    r_mem_din;
    logic [TEST_PORT-1:0]           r_start;
    logic [TEST_PORT-1:0]           r_stop;
    logic [TEST_PORT*64-1:0]        r_port_config;
    logic [63:0]                    r_cmd;
    logic [TEST_PORT-1:0]           r_mask;
    logic [31:0]                    r_dur;
    logic [31:0]                    r_cnt;
    logic [c_cnt_w-1:0]             r_to;
    logic [2:0]                     r_err;
    logic [31:0]                    r_run;
    logic [c_pw-1:0]                r_ld;
    logic [c_pw-1:0]                r_wb_port;
    logic [c_ww-1:0]                r_wb_word;
    logic [TEST_PORT*RES_WORDS*64-1:0] r_snap;
    logic                           r_fin2;
    logic                           r_cmd_vld;

    logic [c_pw-1:0]                w_first_port;
    logic [c_pw-1:0]                w_next_port;
    logic                           w_next_vld;
    logic                           w_ready_ok;
    logic                           w_drain_ok;
    logic                           w_go;

    function automatic logic [MEM_ADDR_WIDTH-1:0] res_addr(input logic [c_pw-1:0] p,
                                                           input logic [c_ww-1:0] w);
        return MEM_ADDR_WIDTH'(c_res_base + int'(p) * RES_WORDS + int'(w));
    endfunction

    function automatic logic [63:0] res_word(input logic [TEST_PORT*RES_WORDS*64-1:0] flat,
                                             input logic [c_pw-1:0] p,
                                             input logic [c_ww-1:0] w);
        return flat[(int'(p) * RES_WORDS + int'(w)) * 64 +: 64];
    endfunction

    assign w_ready_ok = ((gen_ready & check_ready & r_mask) == r_mask);
    assign w_drain_ok = ((check_ready & r_mask) == r_mask);
    // mem_dout only reflects CMD when the previous cycle presented a read of word 0
    assign w_go       = r_cmd_vld && mem_dout[0];

    // Lowest enabled port overall and lowest enabled port above the current one
    always_comb begin
        w_first_port = '0;
        w_next_port  = '0;
        w_next_vld   = 1'b0;
        for (int p = TEST_PORT - 1; p >= 0; p--) begin
            if (r_mask[p]) begin
                w_first_port = c_pw'(p);
            end
            if (r_mask[p] && (c_pw'(p) > r_wb_port)) begin
                w_next_port = c_pw'(p);
                w_next_vld  = 1'b1;
            end
        end
    end

    // Tracks whether the word on mem_dout this cycle is a genuine CMD read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_vld <= 1'b0;
        end else begin
            r_cmd_vld <= (r_mem_addr == '0) && !r_mem_we;
        end
    end

    // Main sequencer; all outputs are registered and default to a CMD read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_start       <= '0;
            r_stop        <= '0;
            r_port_config <= '0;
            r_cmd         <= '0;
            r_mask        <= '0;
            r_dur         <= '0;
            r_cnt         <= '0;
            r_to          <= '0;
            r_err         <= '0;
            r_run         <= '0;
            r_ld          <= '0;
            r_wb_port     <= '0;
            r_wb_word     <= '0;
            r_snap        <= '0;
            r_fin2        <= 1'b0;
        end else begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_start    <= '0;
            r_stop     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_cmd  <= mem_dout;
                        r_mask <= mem_dout[8 +: TEST_PORT];
                        r_dur  <= mem_dout[63:32];
                        if (mem_dout[8 +: TEST_PORT] == '0) begin
                            r_err      <= 3'd2;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= MEM_ADDR_WIDTH'(1);
                            r_mem_din  <= {r_run + 32'd1, 28'd0, 3'd2, 1'b1};
                            r_run      <= r_run + 32'd1;
                            r_fin2     <= 1'b0;
                            r_state    <= S_FINISH;
                        end else begin
                            r_err      <= 3'd0;
                            r_ld       <= '0;
                            r_mem_addr <= MEM_ADDR_WIDTH'(c_cfg_base);
                            r_state    <= S_LOAD_CFG;
                        end
                    end
                end
                S_LOAD_CFG: begin
                    // Address k is issued in LOAD_CFG cycle k, its data captured in cycle k+1
                    if (r_ld != '0) begin
                        r_port_config[(int'(r_ld) - 1) * 64 +: 64] <= mem_dout;
                    end
                    if (int'(r_ld) == TEST_PORT) begin
                        r_to    <= '0;
                        r_state <= S_WAIT_READY;
                    end else begin
                        r_ld <= r_ld + c_pw'(1);
                        if (int'(r_ld) + 1 < TEST_PORT) begin
                            r_mem_addr <= MEM_ADDR_WIDTH'(int'(r_ld) + c_cfg_base + 1);
                        end
                    end
                end
                S_WAIT_READY: begin
                    if (w_ready_ok) begin
                        r_start <= r_mask;
                        r_state <= S_START;
                    end else if (r_to == c_to_last) begin
                        r_err      <= 3'd1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= MEM_ADDR_WIDTH'(1);
                        r_mem_din  <= {r_run + 32'd1, 28'd0, 3'd1, 1'b1};
                        r_run      <= r_run + 32'd1;
                        r_fin2     <= 1'b0;
                        r_state    <= S_FINISH;
                    end else begin
                        r_to <= r_to + c_cnt_w'(1);
                    end
                end
                S_START: begin
                    if (r_dur == 32'd0) begin
                        r_stop  <= r_mask;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt   <= r_dur;
                        r_state <= S_TESTING;
                    end
                end
                S_TESTING: begin
                    if (r_cmd_vld && mem_dout[1]) begin
                        r_err   <= 3'd4;
                        r_stop  <= r_mask;
                        r_state <= S_STOP;
                    end else if (r_cnt == 32'd1) begin
                        r_stop  <= r_mask;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_STOP: begin
                    r_to    <= '0;
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_drain_ok || (r_to == c_to_last)) begin
                        if (!w_drain_ok) begin
                            r_err <= 3'd3;
                        end
                        r_snap     <= check_results;
                        r_wb_port  <= w_first_port;
                        r_wb_word  <= '0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= res_addr(w_first_port, '0);
                        r_mem_din  <= res_word(check_results, w_first_port, '0);
                        r_state    <= S_WRITEBACK;
                    end else begin
                        r_to <= r_to + c_cnt_w'(1);
                    end
                end
                S_WRITEBACK: begin
                    // Disabled ports are skipped without spending a cycle
                    if (int'(r_wb_word) < RES_WORDS - 1) begin
                        r_wb_word  <= r_wb_word + c_ww'(1);
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= res_addr(r_wb_port, r_wb_word + c_ww'(1));
                        r_mem_din  <= res_word(r_snap, r_wb_port, r_wb_word + c_ww'(1));
                    end else if (w_next_vld) begin
                        r_wb_port  <= w_next_port;
                        r_wb_word  <= '0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= res_addr(w_next_port, '0);
                        r_mem_din  <= res_word(r_snap, w_next_port, '0);
                    end else begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= MEM_ADDR_WIDTH'(1);
                        r_mem_din  <= {r_run + 32'd1, 28'd0, r_err, 1'b1};
                        r_run      <= r_run + 32'd1;
                        r_fin2     <= 1'b0;
                        r_state    <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // STATUS is on the bus this cycle; follow with the cleared CMD word
                    if (!r_fin2) begin
                        r_fin2     <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= '0;
                        r_mem_din  <= r_cmd & ~64'h3;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;
    assign start       = r_start;
    assign stop        = r_stop;
    assign port_config = r_port_config;

endmodule
`default_nettype wire

// File: tb/tb_speed_test_controller_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_speed_test_controller_seq
// Description : Scoreboard bench for speed_test_controller_seq with a
//               behavioural control memory and run-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speed_test_controller_seq;

    localparam int MAW = 9;
    localparam int TP  = 4;
    localparam int RW  = 2;
    localparam int RT  = 1024;
    localparam int RES_BASE = 2 + TP;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_we;
    logic [MAW-1:0]    mem_addr;
    logic [63:0]       mem_din;
    logic [63:0]       mem_dout;
    logic [TP-1:0]     gen_ready = '1;
    logic [TP-1:0]     check_ready = '1;
    logic [TP*RW*64-1:0] check_results = '0;
    logic [TP-1:0]     start;
    logic [TP-1:0]     stop;
    logic [TP*64-1:0]  port_config;

    logic              host_we = 1'b0;
    logic [MAW-1:0]    host_addr = '0;
    logic [63:0]       host_din = '0;
    logic [63:0]       mem [0:(1<<MAW)-1];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int t_start = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    logic [31:0] model_run = '0;
    logic [63:0] last_status = '0;
    logic [TP*64-1:0] exp_cfg = '0;

    typedef struct { logic [MAW-1:0] addr; logic [63:0] data; int cyc; } wr_t;
    typedef struct { logic [TP-1:0] mask; int cyc; } pulse_t;
    wr_t    wr_q[$];
    pulse_t start_q[$];
    pulse_t stop_q[$];

    speed_test_controller_seq #(
        .MEM_ADDR_WIDTH(MAW), .TEST_PORT(TP), .RES_WORDS(RW), .READY_TIMEOUT(RT)
    ) dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .gen_ready(gen_ready), .check_ready(check_ready),
        .check_results(check_results), .start(start), .stop(stop), .port_config(port_config)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port memory: controller port with one-cycle read, host write port
    always @(posedge clk) begin
        mem_dout <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_din;
        if (host_we) mem[host_addr] <= host_din;
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected events whenever the DUT presents one
    always @(negedge clk) begin
        pulse_t p;
        wr_t    w;
        if (start != '0 || stop != '0)
            chk((start & stop) == '0, "start_stop_overlap", 64'(start), 64'(stop));
        if (start != '0) begin
            chk(start_q.size() != 0, "start_expected", 64'(start), 64'(0));
            if (start_q.size() != 0) begin
                p = start_q.pop_front();
                chk(start == p.mask, "start_mask", 64'(start), 64'(p.mask));
                chk(cyc == p.cyc, "start_cycle", 64'(cyc), 64'(p.cyc));
                for (int i = 0; i < TP; i++)
                    chk(port_config[i*64 +: 64] == exp_cfg[i*64 +: 64], "port_config",
                        port_config[i*64 +: 64], exp_cfg[i*64 +: 64]);
            end
            t_start = cyc;
            start_cnt++;
        end
        if (stop != '0) begin
            chk(stop_q.size() != 0, "stop_expected", 64'(stop), 64'(0));
            if (stop_q.size() != 0) begin
                p = stop_q.pop_front();
                chk(stop == p.mask, "stop_mask", 64'(stop), 64'(p.mask));
                chk(cyc == t_start + p.cyc, "stop_cycle", 64'(cyc), 64'(t_start + p.cyc));
            end
        end
        if (mem_we) begin
            chk(wr_q.size() != 0, "write_expected", 64'(mem_addr), 64'(0));
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                chk(mem_addr == w.addr, "write_addr", 64'(mem_addr), 64'(w.addr));
                chk(mem_din == w.data, "write_data", mem_din, w.data);
                if (w.cyc >= 0)
                    chk(cyc == w.cyc, "write_cycle", 64'(cyc), 64'(w.cyc));
            end
            if (mem_addr == '0) done_cnt++;
        end
    end

    task automatic host_wr(input logic [MAW-1:0] a, input logic [63:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_din = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // kind: 0 clean, 1 ready timeout, 2 abort, 3 empty mask, 4 drain timeout, 5 reset mid-run
    task automatic run(input int kind, input logic [TP-1:0] mask, input logic [31:0] dur);
        logic [63:0] cmd;
        logic [63:0] status;
        logic [63:0] cfgw;
        logic [2:0]  err;
        int go;
        int prev_done;
        int prev_start;
        int n;
        for (int p = 0; p < TP; p++) begin
            cfgw = {$urandom, $urandom};
            exp_cfg[p*64 +: 64] = cfgw;
            host_wr(MAW'(2 + p), cfgw);
        end
        for (int i = 0; i < TP*RW; i++) check_results[i*64 +: 64] = {$urandom, $urandom};
        gen_ready = '1;
        check_ready = '1;
        if (kind == 1) gen_ready[1] = 1'b0;
        cmd = '0;
        cmd[63:32] = dur;
        cmd[8 +: TP] = mask;
        cmd[0] = 1'b1;
        err = (kind == 1) ? 3'd1 : (kind == 2) ? 3'd4 : (kind == 3) ? 3'd2 : (kind == 4) ? 3'd3 : 3'd0;
        status = {model_run + 32'd1, 28'd0, err, 1'b1};
        prev_done = done_cnt;
        prev_start = start_cnt;

        @(negedge clk);
        go = cyc;
        if (kind == 0 || kind == 2 || kind == 4 || kind == 5) start_q.push_back('{mask, go + 9});
        if (kind == 0 || kind == 4) stop_q.push_back('{mask, 1 + int'(dur)});
        if (kind == 2) stop_q.push_back('{mask, 53});
        if (kind != 5) begin
            if (kind == 0 || kind == 2 || kind == 4)
                for (int p = 0; p < TP; p++)
                    if (mask[p])
                        for (int w = 0; w < RW; w++)
                            wr_q.push_back('{MAW'(RES_BASE + p*RW + w), check_results[(p*RW + w)*64 +: 64], -1});
            wr_q.push_back('{MAW'(1), status, (kind == 1) ? go + 1032 : (kind == 3) ? go + 3 : -1});
            wr_q.push_back('{MAW'(0), cmd & ~64'h3, -1});
        end
        host_we = 1'b1; host_addr = '0; host_din = cmd;
        @(negedge clk);
        host_we = 1'b0;

        if (kind == 2 || kind == 4 || kind == 5) begin
            n = 0;
            while (start_cnt == prev_start && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk(start_cnt != prev_start, "start_timeout", 64'(start_cnt), 64'(prev_start + 1));
            if (kind == 4) check_ready[3] = 1'b0;
            if (kind == 2) begin
                while (cyc < t_start + 50) @(negedge clk);
                host_we = 1'b1; host_addr = '0; host_din = cmd | 64'h2;
                @(negedge clk);
                host_we = 1'b0;
            end
            if (kind == 5) begin
                while (cyc < t_start + 30) @(negedge clk);
                rst = 1'b1;
                host_we = 1'b1; host_addr = '0; host_din = '0;
                @(negedge clk);
                rst = 1'b0;
                host_we = 1'b0;
                chk(mem_we == 1'b0, "rst_mem_we", 64'(mem_we), 64'(0));
                chk(mem_addr == '0, "rst_mem_addr", 64'(mem_addr), 64'(0));
                chk(mem_din == '0, "rst_mem_din", mem_din, 64'(0));
                chk(start == '0 && stop == '0, "rst_pulses", 64'({start, stop}), 64'(0));
                chk(port_config == '0, "rst_port_config", port_config[63:0], 64'(0));
                chk(mem[1] == last_status, "rst_status_unchanged", mem[1], last_status);
                stop_q.delete();
                wr_q.delete();
                model_run = '0;
                repeat (40) @(negedge clk);
                return;
            end
        end

        n = 0;
        while (done_cnt == prev_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(done_cnt != prev_done, "run_done_timeout", 64'(done_cnt), 64'(prev_done + 1));
        @(negedge clk);
        chk(mem[1] == status, "status_mem", mem[1], status);
        chk(mem[0][1:0] == 2'b00, "cmd_cleared", mem[0], cmd & ~64'h3);
        model_run = model_run + 32'd1;
        last_status = status;
        gen_ready = '1;
        check_ready = '1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        host_wr(MAW'(0), 64'd0);
        host_wr(MAW'(1), 64'd0);
        repeat (2) @(negedge clk);
        chk(mem_we == 1'b0 && mem_addr == '0 && mem_din == '0, "reset_mem_port", mem_din, 64'(0));
        chk(start == '0 && stop == '0 && port_config == '0, "reset_outputs", 64'({start, stop}), 64'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run(0, 4'b0101, 32'd100);
        run(1, 4'b0010, 32'd10);
        run(2, 4'b0111, 32'hFFFF_FFFF);
        run(3, 4'b0000, 32'd5);
        run(4, 4'b1001, 32'd20);
        run(5, 4'b1111, 32'd1000);
        run(0, 4'b0011, 32'd0);
        for (int i = 0; i < 6; i++)
            run(0, TP'($urandom_range(1, (1 << TP) - 1)), 32'($urandom_range(0, 60)));

        repeat (10) @(negedge clk);
        chk(wr_q.size() == 0 && start_q.size() == 0 && stop_q.size() == 0, "queues_drained",
            64'(wr_q.size() + start_q.size() + stop_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
